// File: rtl/boolean_if.sv
// Signal bundle for the three-input Boolean function unit.
// The master drives the function inputs; the slave returns the
// combinational result plus its registered and edge-annotated copies.
interface boolean_if #(
    parameter int CNT_W = 8
);
    logic             A;
    logic             B;
    logic             C;
    logic             F;
    logic             F_q;
    logic             f_rise;
    logic             f_fall;
    logic [CNT_W-1:0] hi_cnt;

    modport master (
        output A, B, C,
        input  F, F_q, f_rise, f_fall, hi_cnt
    );

    modport slave (
        input  A, B, C,
        output F, F_q, f_rise, f_fall, hi_cnt
    );
endinterface

// File: rtl/boolean.sv
// Fixed three-input Boolean function: F = TRUTH_TABLE[{A,B,C}].
// Alongside the combinational F it provides a registered copy, one-cycle
// rise/fall strobes on that copy and a saturating count of its high cycles.
module boolean #(
    parameter logic [7:0] TRUTH_TABLE = 8'hCA,
    parameter int         CNT_W       = 8
) (
    input  logic      clk,
    input  logic      rst,
    boolean_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             f;
    logic             f_q_d,    f_q_q;
    logic             f_rise_d, f_rise_q;
    logic             f_fall_d, f_fall_q;
    logic [CNT_W-1:0] hi_cnt_d, hi_cnt_q;

    // Table lookup; independent of clock and reset.
    always_comb begin
        f = TRUTH_TABLE[{bus.A, bus.B, bus.C}];
    end

    // Next-state: edges compare the incoming F against the current F_q, and
    // the counter advances on edges where F_q is already high.
    always_comb begin
        f_q_d    = f;
        f_rise_d = f & ~f_q_q;
        f_fall_d = ~f & f_q_q;
        hi_cnt_d = hi_cnt_q;
        if (f_q_q && (hi_cnt_q != CNT_MAX)) begin
            hi_cnt_d = hi_cnt_q + 1'b1;
        end
    end

    // Registered state; synchronous reset wins over every update.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q_q    <= 1'b0;
            f_rise_q <= 1'b0;
            f_fall_q <= 1'b0;
            hi_cnt_q <= '0;
        end else begin
            f_q_q    <= f_q_d;
            f_rise_q <= f_rise_d;
            f_fall_q <= f_fall_d;
            hi_cnt_q <= hi_cnt_d;
        end
    end

    assign bus.F      = f;
    assign bus.F_q    = f_q_q;
    assign bus.f_rise = f_rise_q;
    assign bus.f_fall = f_fall_q;
    assign bus.hi_cnt = hi_cnt_q;
endmodule

// File: tb/tb_boolean.sv
// Directed bench for the boolean unit: combinational sweep before any clock,
// then clocked steps whose expected registered outputs are pushed to a
// scoreboard queue when driven and popped after the following rising edge.
module tb_boolean;
    localparam int CNT_W = 8;

    typedef struct {
        logic             f;
        logic             f_q;
        logic             f_rise;
        logic             f_fall;
        logic [CNT_W-1:0] hi_cnt;
    } exp_t;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst    = 1'b0;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    // Reference state of the registered outputs
    logic             m_fq   = 1'b0;
    logic [CNT_W-1:0] m_cnt  = '0;

    boolean_if #(.CNT_W(CNT_W)) bus ();

    boolean #(.TRUTH_TABLE(8'hCA), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = clk_en ? ~clk : clk;

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Default table is a 2:1 mux: B when A=1, C when A=0.
    function automatic logic ref_f(input logic a, input logic b, input logic c);
        return a ? b : c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge state,
    // then compare after the edge.
    task automatic step(input logic r, input logic a, input logic b, input logic c, input string tag);
        exp_t e;
        logic nf;
        bus.A = a; bus.B = b; bus.C = c; rst = r;
        nf = ref_f(a, b, c);
        if (r) begin
            e.f_rise = 1'b0; e.f_fall = 1'b0; e.f_q = 1'b0;
            m_cnt = '0; m_fq = 1'b0;
        end else begin
            e.f_rise = nf & ~m_fq;
            e.f_fall = ~nf & m_fq;
            if (m_fq && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
            m_fq = nf;
            e.f_q = nf;
        end
        e.hi_cnt = m_cnt;
        e.f      = nf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_F"},      32'(bus.F),      32'(e.f));
            chk({tag, "_F_q"},    32'(bus.F_q),    32'(e.f_q));
            chk({tag, "_f_rise"}, 32'(bus.f_rise), 32'(e.f_rise));
            chk({tag, "_f_fall"}, 32'(bus.f_fall), 32'(e.f_fall));
            chk({tag, "_hi_cnt"}, 32'(bus.hi_cnt), 32'(e.hi_cnt));
        end
    endtask

    initial begin
        logic [7:0] tab;
        logic [2:0] idx;
        tab = 8'b1100_1010;  // index 7..0 : 1,1,0,0,1,0,1,0

        // Combinational behaviour with no clock and no reset
        bus.A = 1'b0; bus.B = 1'b0; bus.C = 1'b0;
        #5;
        chk("comb_000_noclk", 32'(bus.F), 32'd0);
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            bus.A = idx[2]; bus.B = idx[1]; bus.C = idx[0];
            #5;
            chk($sformatf("comb_sweep_%0d", i), 32'(bus.F), 32'(tab[idx]));
            chk($sformatf("comb_ref_%0d", i), 32'(bus.F), 32'(ref_f(idx[2], idx[1], idx[0])));
        end

        // Reset for two cycles, then release with F=1 (A=1,B=1,C=0)
        clk_en = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0, "rst0");
        step(1'b1, 1'b1, 1'b1, 1'b0, "rst1");
        step(1'b0, 1'b1, 1'b1, 1'b0, "rel_rise");
        chk("rel_rise_pulse", 32'(bus.f_rise), 32'd1);
        chk("rel_cnt_zero",   32'(bus.hi_cnt), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, "hold1");
        chk("hold1_cnt", 32'(bus.hi_cnt), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, "hold2");
        step(1'b0, 0, 1'b0, 1'b1, "hold3_mux_c");

        // Fall: A=1,B=0 -> F=0; counter then holds
        step(1'b0, 1'b1, 1'b0, 1'b0, "fall");
        chk("fall_pulse", 32'(bus.f_fall), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1, "low1");
        step(1'b0, 1'b0, 1'b1, 1'b0, "low2");
        chk("low_cnt_hold", 32'(bus.hi_cnt), 32'd4);

        // Hold F=1 long enough to saturate
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b1, 1'b1, "sat");
        chk("sat_255", 32'(bus.hi_cnt), 32'd255);
        step(1'b0, 1'b0, 1'b0, 1'b1, "sat_more");
        chk("sat_stay", 32'(bus.hi_cnt), 32'd255);

        // Reset mid-count with F=1
        step(1'b1, 1'b1, 1'b1, 1'b1, "mid_rst");
        chk("mid_rst_F_stays", 32'(bus.F), 32'd1);
        chk("mid_rst_cnt", 32'(bus.hi_cnt), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, "post_rst_rise");
        step(1'b0, 1'b1, 1'b1, 1'b1, "post_rst_cnt");
        chk("post_rst_cnt1", 32'(bus.hi_cnt), 32'd1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
